// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Results are computed from latched operands and committed on the last busy cycle.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | accepting requests; MTHI/MTLO write immediately
    // RUN   | multiply/divide in flight, counter running down to commit
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    state_t           state;
    logic [7:0]       cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rt_q;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_wr;

    assign prod_s = $signed({{WIDTH{rs_q[WIDTH-1]}}, rs_q}) * $signed({{WIDTH{rt_q[WIDTH-1]}}, rt_q});
    assign prod_u = {{WIDTH{1'b0}}, rs_q} * {{WIDTH{1'b0}}, rt_q};

    // Signed divide via magnitudes: the most-negative / -1 case falls out naturally
    // since its magnitude quotient wraps back to the most-negative value.
    assign rs_neg = rs_q[WIDTH-1];
    assign rt_neg = rt_q[WIDTH-1];
    assign rs_mag = rs_neg ? (~rs_q + 1'b1) : rs_q;
    assign rt_mag = rt_neg ? (~rt_q + 1'b1) : rt_q;
    assign q_mag  = (rt_mag != '0) ? (rs_mag / rt_mag) : '0;
    assign r_mag  = (rt_mag != '0) ? (rs_mag % rt_mag) : '0;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            OP_DIV: begin
                res_lo = (rs_neg ^ rt_neg) ? (~q_mag + 1'b1) : q_mag;
                res_hi = rs_neg ? (~r_mag + 1'b1) : r_mag;
                res_wr = (rt_q != '0);
            end
            OP_DIVU: begin
                res_lo = (rt_q != '0) ? (rs_q / rt_q) : '0;
                res_hi = (rt_q != '0) ? (rs_q % rt_q) : '0;
                res_wr = (rt_q != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                op_q  <= op;
                                rs_q  <= rs;
                                rt_q  <= rt;
                                cnt   <= 8'(MULT_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q  <= op;
                                rs_q  <= rs;
                                rt_q  <= rt;
                                cnt   <= 8'(DIV_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_MTHI: hi <= rs;
                            OP_MTLO: lo <= rs;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // start is deliberately not examined here, including on the commit edge
                    if (cnt <= 8'd1) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a 64-bit arithmetic reference model.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] hi_m;
    logic [31:0] lo_m;
    int          n_checks;
    int          n_fail;

    mult_div_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request; optionally inject a second start during busy cycle inj_cyc.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input logic [2:0] inj_op, input logic [31:0] inj_rs);
        int          exp_cyc;
        int          cyc;
        bit          stable;
        logic [31:0] hi0;
        logic [31:0] lo0;
        longint      sa;
        longint      sb;
        longint      p;
        longint      q;
        longint      r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned pu;

        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;

        hi0 = hi_m;
        lo0 = lo_m;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        exp_cyc = 0;
        case (o)
            3'd1: begin exp_cyc = MC; p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd2: begin exp_cyc = MC; pu = ua * ub; hi_m = pu[63:32]; lo_m = pu[31:0]; end
            3'd3: begin
                exp_cyc = DC;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    lo_m = q[31:0]; hi_m = r[31:0];
                end
            end
            3'd4: begin
                exp_cyc = DC;
                if (b != 0) begin
                    pu = ua / ub; lo_m = pu[31:0];
                    pu = ua % ub; hi_m = pu[31:0];
                end
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase

        cyc = 0;
        stable = 1'b1;
        while (busy && cyc < 300) begin
            cyc++;
            if (hi !== hi0 || lo !== lo0) stable = 1'b0;
            if (cyc == inj_cyc) begin
                start = 1'b1; op = inj_op; rs = inj_rs;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; op = 3'd0;

        check("busy_cycles", cyc, exp_cyc);
        if (exp_cyc > 0) check("hilo_stable_busy", stable, 1'b1);
        check("busy_after", busy, 1'b0);
        check("hi", hi, hi_m);
        check("lo", lo, lo_m);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        n_checks = 0;
        n_fail   = 0;
        hi_m = '0;
        lo_m = '0;
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd5;
        rs    = 32'hDEADBEEF;
        rt    = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;

        run_op(3'd1, 32'hFFFFFFFE, 32'h00000003, 0, 3'd0, 32'd0);
        check("mult_dir_hi", hi, 32'hFFFFFFFF);
        check("mult_dir_lo", lo, 32'hFFFFFFFA);

        run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 0, 3'd0, 32'd0);
        check("multu_dir_hi", hi, 32'h00000001);
        check("multu_dir_lo", lo, 32'hFFFFFFFE);

        run_op(3'd3, 32'hFFFFFFF9, 32'h00000002, 0, 3'd0, 32'd0);
        check("div_dir_lo", lo, 32'hFFFFFFFD);
        check("div_dir_hi", hi, 32'hFFFFFFFF);

        run_op(3'd5, 32'h12345678, 32'd0, 0, 3'd0, 32'd0);
        run_op(3'd4, 32'h00000055, 32'd0, 0, 3'd0, 32'd0);
        check("divu0_hi", hi, 32'h12345678);

        // MTLO during busy cycle 2 must be dropped
        run_op(3'd1, 32'h00010003, 32'h00020005, 2, 3'd6, 32'hAAAAAAAA);
        check("mtlo_ignored_lo", lo, 32'h000B0000 + 32'h0000000F);

        // MTHI presented on the completing edge must be dropped
        run_op(3'd2, 32'h89ABCDEF, 32'h76543210, MC, 3'd5, 32'h55555555);

        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0, 32'd0);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'd0);

        run_op(3'd0, 32'hCAFEF00D, 32'd1, 0, 3'd0, 32'd0);
        run_op(3'd7, 32'hCAFEF00D, 32'd1, 0, 3'd0, 32'd0);

        // Reset in busy cycle 4 of a divide discards the result
        @(negedge clk);
        start = 1'b1; op = 3'd3; rs = 32'hFFFFFFF9; rt = 32'h00000002;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
        check("rst_run_busy", busy, 1'b0);
        check("rst_run_hi", hi, 32'd0);
        check("rst_run_lo", lo, 32'd0);
        repeat (DC + 2) @(negedge clk);
        check("no_late_busy", busy, 1'b0);
        check("no_late_hi", hi, 32'd0);
        check("no_late_lo", lo, 32'd0);

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 17));
            else if (sel == 3) b = -32'($urandom_range(1, 17));
            run_op(o, a, b, 0, 3'd0, 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width in bits.
REQ-002 The block SHALL have parameter MULT_CYCLES, default 5, giving the busy cycles per multiply; legal range 1..255.
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, giving the busy cycles per divide; legal range 1..255.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: request strobe, sampled only at the rising edge of clk.
REQ-007 Port op, input, 3 bits: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE).
REQ-008 Port rs, input, WIDTH bits: multiplicand, dividend, or MTHI/MTLO source.
REQ-009 Port rt, input, WIDTH bits: multiplier or divisor.
REQ-010 Port busy, output, 1 bit, registered: high while a multiply or divide is in flight.
REQ-011 Port hi, output, WIDTH bits, registered: the HI register.
REQ-012 Port lo, output, WIDTH bits, registered: the LO register.

Function
REQ-013 The block SHALL implement a state machine with two states, IDLE and RUN, and a down-counter of 8 bits.
REQ-014 IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - rs, rt and op SHALL be latched at that edge.
  - The state SHALL become RUN, with the counter loaded to MULT_CYCLES or DIV_CYCLES.
  - busy SHALL rise one cycle after that edge.
REQ-015 RUN: the counter SHALL decrement once per cycle; busy SHALL stay high for exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-016 On the edge that ends the last busy cycle, hi and lo SHALL take the result, busy SHALL fall and the state SHALL return to IDLE.
REQ-017 hi and lo SHALL NOT change while busy=1.
REQ-018 MULT SHALL use signed operands; MULTU SHALL use unsigned operands. {hi,lo} SHALL equal the full 2*WIDTH-bit product.
REQ-019 DIV SHALL use signed operands:
  - lo = quotient, truncated toward zero.
  - hi = remainder, carrying the sign of the dividend.
REQ-020 DIVU SHALL use unsigned operands: lo = quotient, hi = remainder.
REQ-021 Signed overflow (rs = most-negative value, rt = -1) SHALL give lo = most-negative value and hi = 0.
REQ-022 Divide by zero (rt = 0) SHALL:
  - still assert busy for DIV_CYCLES cycles;
  - leave hi and lo unchanged at completion.
REQ-023 IDLE, start=1, op=MTHI: hi SHALL load rs at that edge; busy SHALL stay 0.
REQ-024 IDLE, start=1, op=MTLO: lo SHALL load rs at that edge; busy SHALL stay 0.
REQ-025 In IDLE, start=1 with op NONE or reserved SHALL have no effect.
REQ-026 Any start while busy=1 SHALL be ignored, including MTHI/MTLO; the in-flight result SHALL NOT be disturbed.
REQ-027 A start on the same edge that completes an operation SHALL be ignored; a new operation SHALL be accepted from the following edge only.
REQ-028 The pipeline SHALL stall any HI/LO reader or mult/div issuer on (start & op is MULT/MULTU/DIV/DIVU) | busy; this block SHALL provide no forwarding.
REQ-029 hi and lo SHALL be the registered values only; there SHALL be no combinational path from rs, rt, op or start to busy, hi or lo.

Reset
REQ-030 With reset=1 at a rising edge, the block SHALL set: state IDLE, counter 0, busy 0, hi 0, lo 0.
REQ-031 Reset SHALL take priority over start.
REQ-032 Reset during RUN SHALL discard the pending result; busy SHALL be 0 from the next cycle.
REQ-033 All latched operand registers SHALL clear to 0 on reset.

Verification
REQ-034 The bench SHALL cover: MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 The bench SHALL cover: MULTU rs=0xFFFFFFFF, rt=0x00000002 -> after 5 cycles, hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 The bench SHALL cover: DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-037 The bench SHALL cover: MTHI rs=0x12345678, then DIVU rt=0 -> hi=0x12345678 throughout, busy 10 cycles, hi and lo unchanged after completion.
REQ-038 The bench SHALL cover: MULT started, MTLO rs=0xAAAAAAAA issued in busy cycle 2 -> MTLO ignored, lo = product low word.
REQ-039 The bench SHALL cover: DIV started, reset asserted in busy cycle 4 -> next cycle busy=0, hi=0, lo=0, no late write.
